// File: rtl/fetch_queue_if.sv
// fetch_queue_if
//   Bundles the front-end -> queue and queue -> back-end fetch-pack links
//   together with the queue status outputs.
//   slave  : used by the queue itself (i_* in, o_* out)
//   master : used by whatever drives and observes the queue
//   Ports: i_flush, i_pack_valid/o_pack_ready plus the input pack fields,
//          o_pack_valid/i_pack_ready plus the head pack fields, o_count, o_full.
interface fetch_queue_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 8
);
  localparam int SEL_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int PTR_W = $clog2(DEPTH);

  logic                     i_flush;
  logic                     i_pack_valid;
  logic                     o_pack_ready;
  logic [FETCH_WIDTH-1:0]   i_pack_valids;
  logic [63:0]              i_pack_pc;
  logic [32*FETCH_WIDTH-1:0] i_pack_insts;
  logic                     i_pack_bp_valid;
  logic [63:0]              i_pack_bp_target;
  logic [3:0]               i_pack_bp_type;
  logic [SEL_W-1:0]         i_pack_bp_select;
  logic                     i_pack_bp_taken;

  logic                     o_pack_valid;
  logic                     i_pack_ready;
  logic [FETCH_WIDTH-1:0]   o_pack_valids;
  logic [63:0]              o_pack_pc;
  logic [32*FETCH_WIDTH-1:0] o_pack_insts;
  logic                     o_pack_bp_valid;
  logic [63:0]              o_pack_bp_target;
  logic [3:0]               o_pack_bp_type;
  logic [SEL_W-1:0]         o_pack_bp_select;
  logic                     o_pack_bp_taken;

  logic [PTR_W:0]           o_count;
  logic                     o_full;

  modport slave (
    input  i_flush, i_pack_valid, i_pack_valids, i_pack_pc, i_pack_insts,
           i_pack_bp_valid, i_pack_bp_target, i_pack_bp_type, i_pack_bp_select,
           i_pack_bp_taken, i_pack_ready,
    output o_pack_ready, o_pack_valid, o_pack_valids, o_pack_pc, o_pack_insts,
           o_pack_bp_valid, o_pack_bp_target, o_pack_bp_type, o_pack_bp_select,
           o_pack_bp_taken, o_count, o_full
  );

  modport master (
    output i_flush, i_pack_valid, i_pack_valids, i_pack_pc, i_pack_insts,
           i_pack_bp_valid, i_pack_bp_target, i_pack_bp_type, i_pack_bp_select,
           i_pack_bp_taken, i_pack_ready,
    input  o_pack_ready, o_pack_valid, o_pack_valids, o_pack_pc, o_pack_insts,
           o_pack_bp_valid, o_pack_bp_target, o_pack_bp_type, o_pack_bp_select,
           o_pack_bp_taken, o_count, o_full
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
//   Decoupling queue between fetch front end and back end. Holds up to DEPTH
//   fetch packs (FETCH_WIDTH instructions + branch prediction info) in a
//   circular buffer; head entry is presented combinationally (first-word
//   fall-through). A flush (pc redirect) empties the queue.
//   Ports:
//     clock  - rising-edge clock
//     reset  - synchronous active-high reset
//     bus    - fetch_queue_if.slave: enqueue side (i_pack_*, o_pack_ready),
//              dequeue side (o_pack_*, i_pack_ready), i_flush, o_count, o_full
module fetch_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic          clock,
  input  logic          reset,
  fetch_queue_if.slave  bus
);
  localparam int SEL_W = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [FETCH_WIDTH-1:0]    valids;
    logic [63:0]               pc;
    logic [32*FETCH_WIDTH-1:0] insts;
    logic                      bpValid;
    logic [63:0]               bpTarget;
    logic [3:0]                bpType;
    logic [SEL_W-1:0]          bpSelect;
    logic                      bpTaken;
  } entry_t;

  entry_t         r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic   w_full;
  logic   w_ready;
  logic   w_valid;
  logic   w_enq;
  logic   w_store;
  logic   w_deq;
  entry_t w_inEntry;
  entry_t w_headEntry;

  // Full queues refuse input even if the head leaves this cycle; ready is
  // also forced low for the whole time reset is asserted.
  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_ready = !reset && !w_full;
  assign w_valid = (r_count != '0);

  // Empty packs complete the handshake but take no storage.
  assign w_enq   = bus.i_pack_valid && w_ready;
  assign w_store = w_enq && (|bus.i_pack_valids);
  assign w_deq   = w_valid && bus.i_pack_ready;

  assign w_inEntry.valids   = bus.i_pack_valids;
  assign w_inEntry.pc       = bus.i_pack_pc;
  assign w_inEntry.insts    = bus.i_pack_insts;
  assign w_inEntry.bpValid  = bus.i_pack_bp_valid;
  assign w_inEntry.bpTarget = bus.i_pack_bp_target;
  assign w_inEntry.bpType   = bus.i_pack_bp_type;
  assign w_inEntry.bpSelect = bus.i_pack_bp_select;
  assign w_inEntry.bpTaken  = bus.i_pack_bp_taken;

  // Pointer/count bookkeeping; reset beats flush, flush beats any
  // same-cycle enqueue. Pointers wrap naturally since DEPTH is 2^PTR_W.
  always_ff @(posedge clock) begin
    if (reset || bus.i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_store) r_tail <= r_tail + PTR_W'(1);
      if (w_deq)   r_head <= r_head + PTR_W'(1);
      case ({w_store, w_deq})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is never reset; a flushed enqueue must not land here.
  always_ff @(posedge clock) begin
    if (w_store && !bus.i_flush) begin
      r_mem[r_tail] <= w_inEntry;
    end
  end

  assign w_headEntry = r_mem[r_head];

  assign bus.o_pack_ready     = w_ready;
  assign bus.o_pack_valid     = w_valid;
  assign bus.o_pack_valids    = w_headEntry.valids;
  assign bus.o_pack_pc        = w_headEntry.pc;
  assign bus.o_pack_insts     = w_headEntry.insts;
  assign bus.o_pack_bp_valid  = w_headEntry.bpValid;
  assign bus.o_pack_bp_target = w_headEntry.bpTarget;
  assign bus.o_pack_bp_type   = w_headEntry.bpType;
  assign bus.o_pack_bp_select = w_headEntry.bpSelect;
  assign bus.o_pack_bp_taken  = w_headEntry.bpTaken;
  assign bus.o_count          = r_count;
  assign bus.o_full           = w_full;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
//   Bench for fetch_queue. Instance A (FETCH_WIDTH=2, DEPTH=8) runs a table of
//   directed vectors; instance B (FETCH_WIDTH=4, DEPTH=4) runs a random stream
//   against a queue-based reference model, including a mid-stream reset.
module tb_fetch_queue;
  logic clock;
  logic resetA;
  logic resetB;
  int   checks;
  int   errors;

  fetch_queue_if #(.FETCH_WIDTH(2), .DEPTH(8)) ifA ();
  fetch_queue_if #(.FETCH_WIDTH(4), .DEPTH(4)) ifB ();

  fetch_queue #(.FETCH_WIDTH(2), .DEPTH(8)) dutA (
    .clock (clock),
    .reset (resetA),
    .bus   (ifA)
  );

  fetch_queue #(.FETCH_WIDTH(4), .DEPTH(4)) dutB (
    .clock (clock),
    .reset (resetB),
    .bus   (ifB)
  );

  // 10 time-unit clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something never finishes
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        flush;
    logic        pv;
    logic [1:0]  valids;
    logic [63:0] pc;
    logic        rdy;
    int          expCount;
    logic        expValid;
    logic        expReady;
    logic [63:0] expPc;
    logic [1:0]  expValids;
  } vec_t;

  typedef struct {
    logic [3:0]   valids;
    logic [63:0]  pc;
    logic [127:0] insts;
    logic         bpv;
    logic [63:0]  tgt;
    logic [3:0]   typ;
    logic [1:0]   sel;
    logic         tkn;
  } packB_t;

  vec_t   vecs[$];
  packB_t model[$];

  // Single comparison point used everywhere
  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void addVec(input logic flush, input logic pv, input logic [1:0] valids,
                                 input logic [63:0] pc, input logic rdy, input int expCount,
                                 input logic expValid, input logic expReady,
                                 input logic [63:0] expPc, input logic [1:0] expValids);
    vec_t v;
    v.flush = flush; v.pv = pv; v.valids = valids; v.pc = pc; v.rdy = rdy;
    v.expCount = expCount; v.expValid = expValid; v.expReady = expReady;
    v.expPc = expPc; v.expValids = expValids;
    vecs.push_back(v);
  endfunction

  // Instance A side-band fields are a fixed function of the pc
  task automatic applyStimulus(input vec_t v);
    ifA.i_flush          = v.flush;
    ifA.i_pack_valid     = v.pv;
    ifA.i_pack_valids    = v.valids;
    ifA.i_pack_pc        = v.pc;
    ifA.i_pack_insts     = {~v.pc[31:0], v.pc[31:0]};
    ifA.i_pack_bp_valid  = v.pc[5];
    ifA.i_pack_bp_target = v.pc + 64'h100;
    ifA.i_pack_bp_type   = v.pc[7:4];
    ifA.i_pack_bp_select = v.pc[3];
    ifA.i_pack_bp_taken  = v.pc[4];
    ifA.i_pack_ready     = v.rdy;
  endtask

  function automatic packB_t randPack();
    packB_t p;
    p.valids = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
    p.pc     = {$urandom, $urandom};
    p.insts  = {$urandom, $urandom, $urandom, $urandom};
    p.bpv    = 1'($urandom);
    p.tgt    = {$urandom, $urandom};
    p.typ    = 4'($urandom);
    p.sel    = 2'($urandom);
    p.tkn    = 1'($urandom);
    return p;
  endfunction

  initial begin
    vec_t   v;
    packB_t cur;
    packB_t hd;
    logic   holding;
    logic   pv, rdy, fl, doReset, didReset, accept, deq;
    int     pushed, cycles;

    checks = 0;
    errors = 0;
    resetA = 1'b1;
    resetB = 1'b1;
    v = '{default: '0};
    applyStimulus(v);
    ifB.i_flush = 0; ifB.i_pack_valid = 0; ifB.i_pack_valids = 0; ifB.i_pack_pc = 0;
    ifB.i_pack_insts = 0; ifB.i_pack_bp_valid = 0; ifB.i_pack_bp_target = 0;
    ifB.i_pack_bp_type = 0; ifB.i_pack_bp_select = 0; ifB.i_pack_bp_taken = 0;
    ifB.i_pack_ready = 0;

    // Directed table for instance A
    addVec(0, 1, 2'b11, 64'h8000_0000, 0, 1, 1, 1, 64'h8000_0000, 2'b11);
    addVec(0, 0, 2'b11, 64'h0, 1, 0, 0, 1, 64'h0, 2'b00);
    for (int k = 0; k < 8; k++)
      addVec(0, 1, 2'b11, 64'(k * 8), 0, k + 1, 1, (k < 7), 64'h0, 2'b11);
    addVec(0, 1, 2'b11, 64'h40, 0, 8, 1, 0, 64'h0, 2'b11);
    addVec(0, 1, 2'b11, 64'h40, 1, 7, 1, 1, 64'h8, 2'b11);
    addVec(0, 1, 2'b11, 64'h40, 0, 8, 1, 0, 64'h8, 2'b11);
    for (int k = 1; k < 8; k++)
      addVec(0, 0, 2'b00, 64'h0, 1, 8 - k, 1, 1, 64'(8 * (k + 1)), 2'b11);
    addVec(0, 0, 2'b00, 64'h0, 1, 0, 0, 1, 64'h0, 2'b00);
    for (int k = 0; k < 5; k++)
      addVec(0, 1, 2'b10, 64'(32'h100 + k * 16), 0, k + 1, 1, 1, 64'h100, 2'b10);
    addVec(1, 1, 2'b11, 64'h200, 0, 0, 0, 1, 64'h0, 2'b00);
    addVec(0, 0, 2'b00, 64'h0, 0, 0, 0, 1, 64'h0, 2'b00);
    addVec(0, 1, 2'b00, 64'h300, 0, 0, 0, 1, 64'h0, 2'b00);
    addVec(0, 1, 2'b01, 64'h310, 0, 1, 1, 1, 64'h310, 2'b01);
    addVec(0, 1, 2'b00, 64'h320, 1, 0, 0, 1, 64'h0, 2'b00);
    addVec(0, 1, 2'b11, 64'h400, 0, 1, 1, 1, 64'h400, 2'b11);
    addVec(0, 1, 2'b11, 64'h410, 0, 2, 1, 1, 64'h400, 2'b11);
    addVec(1, 0, 2'b00, 64'h0, 1, 0, 0, 1, 64'h0, 2'b00);

    // Reset behaviour of instance A
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rstReadyLow", 128'(ifA.o_pack_ready), 128'(0));
    checkOutput("rstValidLow", 128'(ifA.o_pack_valid), 128'(0));
    resetA = 1'b0;
    #1;
    checkOutput("postRstReady", 128'(ifA.o_pack_ready), 128'(1));
    checkOutput("postRstCount", 128'(ifA.o_count), 128'(0));
    checkOutput("postRstFull", 128'(ifA.o_full), 128'(0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d.count", i), 128'(ifA.o_count), 128'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d.valid", i), 128'(ifA.o_pack_valid), 128'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d.ready", i), 128'(ifA.o_pack_ready), 128'(vecs[i].expReady));
      checkOutput($sformatf("vec%0d.full", i), 128'(ifA.o_full), 128'(vecs[i].expCount == 8));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d.pc", i), 128'(ifA.o_pack_pc), 128'(vecs[i].expPc));
        checkOutput($sformatf("vec%0d.valids", i), 128'(ifA.o_pack_valids), 128'(vecs[i].expValids));
        checkOutput($sformatf("vec%0d.insts", i), 128'(ifA.o_pack_insts),
                    128'({~vecs[i].expPc[31:0], vecs[i].expPc[31:0]}));
        checkOutput($sformatf("vec%0d.bpTarget", i), 128'(ifA.o_pack_bp_target),
                    128'(vecs[i].expPc + 64'h100));
      end
    end
    v = '{default: '0};
    applyStimulus(v);

    // Random stream on instance B against the reference queue
    @(posedge clock);
    #1;
    resetB = 1'b0;
    holding = 0; didReset = 0; pushed = 0; cycles = 0;
    cur = randPack();
    while (!(pushed >= 100 && model.size() == 0 && !holding) && cycles < 4000) begin
      cycles++;
      doReset = !didReset && (pushed >= 50);
      if (doReset) begin
        pv = 0;
      end else if (holding) begin
        pv = 1;
      end else begin
        pv = (pushed < 100) && ($urandom_range(0, 3) != 0);
        if (pv) cur = randPack();
      end
      fl  = !doReset && ($urandom_range(0, 29) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      resetB               = doReset;
      ifB.i_flush          = fl;
      ifB.i_pack_valid     = pv;
      ifB.i_pack_valids    = cur.valids;
      ifB.i_pack_pc        = cur.pc;
      ifB.i_pack_insts     = cur.insts;
      ifB.i_pack_bp_valid  = cur.bpv;
      ifB.i_pack_bp_target = cur.tgt;
      ifB.i_pack_bp_type   = cur.typ;
      ifB.i_pack_bp_select = cur.sel;
      ifB.i_pack_bp_taken  = cur.tkn;
      ifB.i_pack_ready     = rdy;
      #1;
      checkOutput("strm.count", 128'(ifB.o_count), 128'(model.size()));
      checkOutput("strm.valid", 128'(ifB.o_pack_valid), 128'(model.size() != 0));
      checkOutput("strm.ready", 128'(ifB.o_pack_ready), 128'(!doReset && model.size() != 4));
      checkOutput("strm.full", 128'(ifB.o_full), 128'(model.size() == 4));
      if (model.size() != 0) begin
        hd = model[0];
        checkOutput("strm.pc", 128'(ifB.o_pack_pc), 128'(hd.pc));
        checkOutput("strm.valids", 128'(ifB.o_pack_valids), 128'(hd.valids));
        checkOutput("strm.insts", ifB.o_pack_insts, hd.insts);
        checkOutput("strm.bp", 128'({ifB.o_pack_bp_valid, ifB.o_pack_bp_target, ifB.o_pack_bp_type,
                                     ifB.o_pack_bp_select, ifB.o_pack_bp_taken}),
                    128'({hd.bpv, hd.tgt, hd.typ, hd.sel, hd.tkn}));
      end
      accept = pv && !doReset && (model.size() != 4);
      deq    = !doReset && rdy && (model.size() != 0);
      @(posedge clock);
      #1;
      if (doReset) begin
        model.delete();
        didReset = 1;
        resetB   = 0;
        holding  = 0;
      end else if (fl) begin
        model.delete();
        holding = pv && !accept;
      end else begin
        if (deq) void'(model.pop_front());
        if (accept && cur.valids != 4'b0000) begin
          model.push_back(cur);
          pushed++;
        end
        holding = pv && !accept;
      end
    end
    checkOutput("strm.finished", 128'(cycles < 4000), 128'(1));
    checkOutput("strm.resetSeen", 128'(didReset), 128'(1));
    ifB.i_pack_valid = 0;
    ifB.i_flush      = 0;
    #1;
    checkOutput("strm.endCount", 128'(ifB.o_count), 128'(model.size()));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
